// File: rtl/kernel_cc_start_sched_if.sv
// Start-FIFO scheduler bus: producer requests, FIFO write side, consumer retire and status.
// master = scheduler side, slave = surrounding producers/FIFO/consumer.
interface kernel_cc_start_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int CNT_WIDTH = 3
);
  logic [NUM_REQ-1:0]   req_start;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_full_n;
  logic                 fifo_write;
  logic [ID_WIDTH-1:0]  fifo_din;
  logic                 cons_done;
  logic                 busy;
  logic [CNT_WIDTH-1:0] outstanding;

  modport master (
    input  req_start, fifo_full_n, cons_done,
    output req_ready, fifo_write, fifo_din, busy, outstanding
  );

  modport slave (
    output req_start, fifo_full_n, cons_done,
    input  req_ready, fifo_write, fifo_din, busy, outstanding
  );
endinterface

// File: rtl/kernel_cc_start_sched.sv
// Round-robin arbiter pushing the winning requester ID into a shared start FIFO; 1-cycle grant latency.
// Optional outstanding-token credit limit under macro KERNEL_CC_START_SCHED_CREDIT_EN.
module kernel_cc_start_sched #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int MAX_OUT   = 4,
  parameter int CNT_WIDTH = 3
) (
  input logic                     clk,
  input logic                     reset,
  kernel_cc_start_sched_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;

  logic                 accept;
  logic                 credit_ok;
  logic                 any_req;
  logic                 found_hi;
  logic [ID_WIDTH-1:0]  win_hi, win_lo, winner;

  assign accept = (state_q == GRANT) && bus.fifo_full_n;

  // Prefer the lowest requester above last_grant; otherwise wrap to the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    any_req  = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_start[i] && (i > int'(last_grant_q)) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = ID_WIDTH'(i);
      end
      if (bus.req_start[i] && !any_req) begin
        any_req = 1'b1;
        win_lo  = ID_WIDTH'(i);
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

`ifdef KERNEL_CC_START_SCHED_CREDIT_EN
  logic dec;

  assign credit_ok = (outstanding_q != CNT_WIDTH'(MAX_OUT));
  assign dec       = bus.cons_done && (outstanding_q != '0);

  // A coincident accept and retire cancel each other out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !dec) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!accept && dec) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end
`else
  localparam int unused_max_out = MAX_OUT;
  logic unused_cons_done;

  assign unused_cons_done = bus.cons_done;
  assign credit_ok        = 1'b1;
  assign outstanding_d    = '0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_req && credit_ok) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.fifo_full_n) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= ID_WIDTH'(NUM_REQ - 1);
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
    end
  end

  // The acknowledge must coincide with the accepted write, so it follows fifo_full_n directly.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (grant_q == ID_WIDTH'(i));
    end
  end

  assign bus.fifo_write  = (state_q == GRANT);
  assign bus.busy        = (state_q != IDLE);
  assign bus.fifo_din    = grant_q;
  assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_kernel_cc_start_sched.sv
// Directed bench for kernel_cc_start_sched: reset, round-robin order, stall, late drop, reset in GRANT, credit.
module tb_kernel_cc_start_sched;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  kernel_cc_start_sched_if #(.NUM_REQ(4), .ID_WIDTH(2), .CNT_WIDTH(3)) bus ();

  kernel_cc_start_sched #(
    .NUM_REQ(4), .ID_WIDTH(2), .MAX_OUT(4), .CNT_WIDTH(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_exp [5];
  logic [3:0] rr_rdy [5];

  initial begin
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b1;
    bus.req_start   = 4'b0000;
    bus.fifo_full_n = 1'b1;
    bus.cons_done   = 1'b0;
    tick();
    tick();
    chk("rst_write", bus.fifo_write, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_din", bus.fifo_din, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_outstanding", bus.outstanding, 0);

    // Single requester 0: write one cycle after the request, ack in the same cycle.
    reset = 1'b0;
    tick();
    bus.req_start = 4'b0001;
    tick();
    chk("single_write", bus.fifo_write, 1);
    chk("single_din", bus.fifo_din, 0);
    chk("single_ready", bus.req_ready, 4'b0001);
    chk("single_busy", bus.busy, 1);
    bus.req_start = 4'b0000;
    tick();
    chk("single_idle_write", bus.fifo_write, 0);
    chk("single_idle_busy", bus.busy, 0);
    chk("single_idle_ready", bus.req_ready, 0);

    // All requesting from reset: 0,1,2,3,0 with one token every 2 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_start = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr_write", bus.fifo_write, 1);
      chk("rr_din", bus.fifo_din, rr_exp[n]);
      chk("rr_ready", bus.req_ready, rr_rdy[n]);
      tick();
      chk("rr_gap_write", bus.fifo_write, 0);
    end
    bus.req_start = 4'b0000;

    // FIFO full for 5 cycles: write held, din stable, ack only once space appears.
    bus.req_start   = 4'b0100;
    bus.fifo_full_n = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("stall_write", bus.fifo_write, 1);
      chk("stall_din", bus.fifo_din, 2);
      chk("stall_ready", bus.req_ready, 0);
    end
    bus.fifo_full_n = 1'b1;
    #1;
    chk("stall_release_ready", bus.req_ready, 4'b0100);
    chk("stall_release_write", bus.fifo_write, 1);
    bus.req_start = 4'b0000;
    tick();
    chk("stall_done_write", bus.fifo_write, 0);

    // Request dropped while stalled: the latched grant still commits.
    bus.req_start   = 4'b0010;
    bus.fifo_full_n = 1'b0;
    tick();
    chk("drop_din0", bus.fifo_din, 1);
    bus.req_start = 4'b0000;
    tick();
    chk("drop_write", bus.fifo_write, 1);
    chk("drop_din", bus.fifo_din, 1);
    bus.fifo_full_n = 1'b1;
    #1;
    chk("drop_ready", bus.req_ready, 4'b0010);
    tick();
    chk("drop_done_write", bus.fifo_write, 0);

    // last_grant=1: requesters 0 and 3 -> 3 first, then wrap to 0.
    bus.req_start = 4'b1001;
    tick();
    chk("wrap_din_a", bus.fifo_din, 3);
    chk("wrap_ready_a", bus.req_ready, 4'b1000);
    tick();
    chk("wrap_gap", bus.fifo_write, 0);
    tick();
    chk("wrap_din_b", bus.fifo_din, 0);
    chk("wrap_ready_b", bus.req_ready, 4'b0001);
    bus.req_start = 4'b0000;
    tick();

    // Reset while stalled in GRANT drops the token; requester 0 wins next.
    bus.req_start   = 4'b0100;
    bus.fifo_full_n = 1'b0;
    tick();
    chk("rg_write_pre", bus.fifo_write, 1);
    reset = 1'b1;
    tick();
    chk("rg_write", bus.fifo_write, 0);
    chk("rg_busy", bus.busy, 0);
    chk("rg_outstanding", bus.outstanding, 0);
    chk("rg_ready", bus.req_ready, 0);
    reset = 1'b0;
    bus.fifo_full_n = 1'b1;
    bus.req_start   = 4'b1111;
    tick();
    chk("rg_next_write", bus.fifo_write, 1);
    chk("rg_next_din", bus.fifo_din, 0);
    bus.req_start = 4'b0000;
    tick();

`ifdef KERNEL_CC_START_SCHED_CREDIT_EN
    // Credit limit of 4 with no retirements: four writes, then stall.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_start = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("cr_write", bus.fifo_write, 1);
      tick();
      chk("cr_out", bus.outstanding, n + 1);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("cr_stall_write", bus.fifo_write, 0);
    end
    chk("cr_out_full", bus.outstanding, 4);
    bus.cons_done = 1'b1;
    tick();
    bus.cons_done = 1'b0;
    chk("cr_out_retire", bus.outstanding, 3);
    chk("cr_retire_write", bus.fifo_write, 0);
    tick();
    chk("cr_extra_write", bus.fifo_write, 1);
    tick();
    chk("cr_out_refill", bus.outstanding, 4);
    tick();
    chk("cr_restall_write", bus.fifo_write, 0);

    // Accept and retire coincide at outstanding=2.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("cr_same_pre", bus.outstanding, 2);
    tick();
    chk("cr_same_grant", bus.fifo_write, 1);
    bus.cons_done = 1'b1;
    tick();
    bus.cons_done = 1'b0;
    chk("cr_same_out", bus.outstanding, 2);
    bus.req_start = 4'b0000;
`else
    // No credit: cons_done ignored, outstanding stays 0, never stalls.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_start = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("nc_write", bus.fifo_write, 1);
      bus.cons_done = 1'b1;
      tick();
      bus.cons_done = 1'b0;
      chk("nc_out", bus.outstanding, 0);
    end
    bus.req_start = 4'b0000;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
